instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction-fetch stage of the CSE-BUBBLE core. It owns the program counter and is the requesting side of the instruction-memory interface. Each cycle it drives a word address to instruction memory, which returns a 32-bit instruction combinationally in the same cycle. The fetched word is captured into the IF/ID pipeline register. The block resolves unconditional jumps (opcode `010100`) in fetch with zero bubbles, honours decode stalls and later-stage redirects, and stops fetching on a HALT opcode.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `JUMP_OP`, default 6'b010100: opcode resolved in fetch.
- `HALT_OP`, default 6'b111111: opcode that stops fetch.
- `clk`  input  1: the single clock. All state updates on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `imem_addr`  output  16: word address to instruction memory. Always equals `pc`.
- `imem_instr`  input  32: instruction word from memory. Valid in the same cycle as `imem_addr`.
- `stall`  input  1: decode cannot accept. IF/ID and PC hold.
- `redirect`  input  1: later stage overrides the PC (branch or exception).
- `redirect_pc`  input  16: target used when `redirect` is high.
- `ifid_valid`  output  1: IF/ID holds a real instruction.
- `ifid_instr`  output  32: latched instruction.
- `ifid_pc`  output  16: address of the latched instruction.
- `halted`  output  1: high while the FSM is in HALT.

## Operation
- `op = imem_instr[31:26]`.
- `imm = imem_instr[15:0]`, treated as signed.
- FSM states and transitions:
  - BOOT: the single cycle after reset release. No capture; `ifid_valid` stays 0. Moves to RUN.
  - RUN: normal fetch.
  - HALT: PC frozen, no new captures.
- Next-PC priority, evaluated each cycle in RUN:
  1. `redirect`: pc ← `redirect_pc`. IF/ID cleared (`ifid_valid`←0). Applies even when `stall` is high.
  2. `stall`: pc and IF/ID hold their values.
  3. `op == JUMP_OP`: IF/ID ← {1, instr, pc}. pc ← pc + 1 + imm, truncated to 16 bits.
  4. `op == HALT_OP`: IF/ID ← {1, instr, pc}. pc holds. Go to HALT.
  5. Otherwise: IF/ID ← {1, instr, pc}. pc ← pc + 1.
- In HALT:
  - When `stall` is low, `ifid_valid` is cleared one cycle after entry, so the HALT word is presented exactly once.
  - `redirect` moves the FSM to RUN with pc ← `redirect_pc` and IF/ID cleared.
  - Nothing else leaves HALT except reset.
- Arithmetic is modulo 2^16:
  - pc 16'hFFFF + 1 → 16'h0000.
  - A jump target computed from imm wraps the same way.
- `imem_addr` is driven directly from the pc register, with no combinational path from `imem_instr`.

## Timing
- Reset values:
  - pc = `RESET_PC`
  - FSM state = BOOT
  - `ifid_valid` = 0
  - `ifid_instr` = 0
  - `ifid_pc` = 0
  - `halted` = 0
- Fetch latency: the word at address A appears on `ifid_instr` one cycle after `imem_addr` = A.
- The first valid IF/ID after reset release occurs at the second rising edge: edge 1 is BOOT→RUN, edge 2 captures mem[`RESET_PC`].
- A jump costs 0 bubbles. The target address is driven in the cycle after the jump is captured.
- `redirect` inserts exactly one bubble: `ifid_valid` = 0 for one cycle, then the target word is captured.
- If `redirect` and `stall` are high in the same cycle, redirect wins and the stall is ignored for that cycle.
- When `stall` falls, capture resumes on the same edge. No instruction is lost or duplicated.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge.
- `halted` is registered and goes high on the edge that captures the HALT word.

## Test plan
- Reset then run, memory holding mem[0]=ADD, mem[1]=J imm 2, mem[4..6]=ops → `ifid_pc` sequence 0, 1, 4, 5, 6. The first valid capture occurs 2 edges after `rst_n` rises.
- `stall` held high for 3 cycles while `ifid_pc`=4 → `ifid_pc`/`ifid_instr` hold 4/mem[4] and `imem_addr` holds 5. On release, the next capture is 5.
- `redirect`=1 with `redirect_pc`=16'h0010 while `stall`=1 → the following cycle has `ifid_valid`=0 and `imem_addr`=16'h0010. The cycle after that captures `ifid_pc`=16'h0010.
- pc=16'hFFFF holding a non-jump word → next `imem_addr`=16'h0000. A jump at 16'h0000 with imm=16'hFFFE (−2) → target 16'hFFFF.
- HALT word (opcode 111111) at address 7 → captured once with `ifid_pc`=7 and `halted`=1. `ifid_valid` drops the next cycle and `imem_addr` stays 7. A later `redirect` to 0 restarts fetch.
- `rst_n` pulsed low for less than one clock period during a jump → outputs return to reset values asynchronously, and fetch restarts from `RESET_PC` through BOOT.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/response, pipeline control
// from later stages, and the IF/ID register presented to decode.
interface instr_fetch_unit_if;
  logic [15:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic        halted;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  stall,
    input  redirect,
    input  redirect_pc,
    output ifid_valid,
    output ifid_instr,
    output ifid_pc,
    output halted
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output stall,
    output redirect,
    output redirect_pc,
    input  ifid_valid,
    input  ifid_instr,
    input  ifid_pc,
    input  halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, resolves unconditional jumps in fetch
// with no bubble, honours decode stalls and later-stage redirects, stops on HALT.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [5:0]  JUMP_OP  = 6'b010100,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [15:0] ifpc_q, ifpc_d;
  logic        halted_q, halted_d;

  logic [5:0]  op;
  logic [15:0] imm;

  assign op  = bus.imem_instr[31:26];
  assign imm = bus.imem_instr[15:0];

  // Redirect outranks stall in every state; the jump target wraps modulo 2^16
  // because the signed immediate is added at full 16-bit width.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    ifpc_d   = ifpc_q;
    halted_d = halted_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (bus.redirect) begin
          pc_d    = bus.redirect_pc;
          valid_d = 1'b0;
        end else if (!bus.stall) begin
          valid_d = 1'b1;
          instr_d = bus.imem_instr;
          ifpc_d  = pc_q;
          if (op == JUMP_OP) begin
            pc_d = pc_q + 16'd1 + imm;
          end else if (op == HALT_OP) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_q + 16'd1;
          end
        end
      end
      HALT: begin
        if (bus.redirect) begin
          state_d  = RUN;
          pc_d     = bus.redirect_pc;
          valid_d  = 1'b0;
          halted_d = 1'b0;
        end else if (!bus.stall) begin
          valid_d = 1'b0;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= 32'h0;
      ifpc_q   <= 16'h0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      ifpc_q   <= ifpc_d;
      halted_q <= halted_d;
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.ifid_valid = valid_q;
  assign bus.ifid_instr = instr_q;
  assign bus.ifid_pc    = ifpc_q;
  assign bus.halted     = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a program-level fetch model checked
// every cycle, plus hand-computed expectations at the interesting points.
module tb_instr_fetch_unit;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  instr_fetch_unit_if bus ();

  instr_fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] memArr [0:65535];
  assign bus.imem_instr = memArr[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the fetch stream: where the program counter is, what decode sees.
  logic [15:0] mPc;
  logic        mBootPending;
  logic        mHalted;
  logic        mValid;
  logic [31:0] mInstr;
  logic [15:0] mIfPc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPc = 16'h0000; mBootPending = 1'b1; mHalted = 1'b0;
      mValid = 1'b0; mInstr = 32'h0; mIfPc = 16'h0;
    end else if (mBootPending) begin
      mBootPending = 1'b0;
    end else if (bus.redirect) begin
      mPc = bus.redirect_pc; mValid = 1'b0; mHalted = 1'b0;
    end else if (mHalted) begin
      if (!bus.stall) mValid = 1'b0;
    end else if (!bus.stall) begin
      mValid = 1'b1;
      mInstr = memArr[mPc];
      mIfPc  = mPc;
      if (mInstr[31:26] == 6'b010100)
        mPc = 16'((int'(mPc) + 1 + int'($signed(mInstr[15:0]))) % 65536);
      else if (mInstr[31:26] == 6'b111111)
        mHalted = 1'b1;
      else
        mPc = 16'((int'(mPc) + 1) % 65536);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      checkOutput("model imem_addr", 32'(bus.imem_addr), 32'(mPc));
      checkOutput("model ifid_valid", 32'(bus.ifid_valid), 32'(mValid));
      checkOutput("model halted", 32'(bus.halted), 32'(mHalted));
      if (mValid) begin
        checkOutput("model ifid_instr", bus.ifid_instr, mInstr);
        checkOutput("model ifid_pc", 32'(bus.ifid_pc), 32'(mIfPc));
      end
    end
  end

  task automatic applyStimulus(input logic st, input logic rd, input logic [15:0] rpc);
    @(negedge clk);
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #2;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " ifid_valid"}, 32'(bus.ifid_valid), 32'h0);
    checkOutput({tag, " ifid_instr"}, bus.ifid_instr, 32'h0);
    checkOutput({tag, " ifid_pc"}, 32'(bus.ifid_pc), 32'h0);
    checkOutput({tag, " halted"}, 32'(bus.halted), 32'h0);
    checkOutput({tag, " imem_addr"}, 32'(bus.imem_addr), 32'h0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 65536; i++) memArr[i] = 32'h0000_0000;
    memArr[0]        = 32'h0000_1111;
    memArr[1]        = 32'h5000_0002;
    memArr[4]        = 32'h0400_0004;
    memArr[5]        = 32'h0400_0005;
    memArr[6]        = 32'h0400_0006;
    memArr[7]        = 32'hFC00_0007;
    memArr[16'h0010] = 32'h0800_0010;
    memArr[16'hFFFF] = 32'h0C00_FFFF;

    rst_n = 1'b0;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 16'h0;
    #1;
    checkResetState("reset");
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    nextEdge();
    checkOutput("boot no capture", 32'(bus.ifid_valid), 32'h0);
    nextEdge();
    checkOutput("first capture valid", 32'(bus.ifid_valid), 32'h1);
    checkOutput("first capture pc", 32'(bus.ifid_pc), 32'h0);
    checkOutput("first capture instr", bus.ifid_instr, 32'h0000_1111);
    nextEdge();
    checkOutput("jump captured pc", 32'(bus.ifid_pc), 32'h1);
    checkOutput("jump target addr", 32'(bus.imem_addr), 32'h4);
    nextEdge();
    checkOutput("after jump pc", 32'(bus.ifid_pc), 32'h4);

    applyStimulus(1'b1, 1'b0, 16'h0);
    nextEdge(); nextEdge(); nextEdge();
    checkOutput("stall hold pc", 32'(bus.ifid_pc), 32'h4);
    checkOutput("stall hold instr", bus.ifid_instr, 32'h0400_0004);
    checkOutput("stall hold addr", 32'(bus.imem_addr), 32'h5);
    applyStimulus(1'b0, 1'b0, 16'h0);
    nextEdge();
    checkOutput("stall release pc", 32'(bus.ifid_pc), 32'h5);
    nextEdge();
    nextEdge();
    checkOutput("halt word pc", 32'(bus.ifid_pc), 32'h7);
    checkOutput("halt word valid", 32'(bus.ifid_valid), 32'h1);
    checkOutput("halted set", 32'(bus.halted), 32'h1);
    nextEdge();
    checkOutput("halt valid drop", 32'(bus.ifid_valid), 32'h0);
    checkOutput("halt addr frozen", 32'(bus.imem_addr), 32'h7);
    nextEdge();
    checkOutput("still halted", 32'(bus.halted), 32'h1);

    applyStimulus(1'b0, 1'b1, 16'h0000);
    nextEdge();
    checkOutput("restart halted clear", 32'(bus.halted), 32'h0);
    checkOutput("restart addr", 32'(bus.imem_addr), 32'h0);
    applyStimulus(1'b0, 1'b0, 16'h0);
    nextEdge(); nextEdge(); nextEdge();
    checkOutput("rerun pc", 32'(bus.ifid_pc), 32'h4);

    applyStimulus(1'b1, 1'b1, 16'h0010);
    nextEdge();
    checkOutput("redirect bubble", 32'(bus.ifid_valid), 32'h0);
    checkOutput("redirect addr", 32'(bus.imem_addr), 32'h10);
    applyStimulus(1'b0, 1'b0, 16'h0);
    nextEdge();
    checkOutput("redirect capture pc", 32'(bus.ifid_pc), 32'h10);
    checkOutput("redirect capture valid", 32'(bus.ifid_valid), 32'h1);

    memArr[0] = 32'h5000_FFFE;
    applyStimulus(1'b0, 1'b1, 16'hFFFF);
    nextEdge();
    checkOutput("top addr", 32'(bus.imem_addr), 32'hFFFF);
    applyStimulus(1'b0, 1'b0, 16'h0);
    nextEdge();
    checkOutput("wrap capture pc", 32'(bus.ifid_pc), 32'hFFFF);
    checkOutput("wrap addr", 32'(bus.imem_addr), 32'h0);
    nextEdge();
    checkOutput("neg jump pc", 32'(bus.ifid_pc), 32'h0);
    checkOutput("neg jump target", 32'(bus.imem_addr), 32'hFFFF);

    memArr[0] = 32'h0000_1111;
    nextEdge();
    #1 rst_n = 1'b0;
    #1 checkResetState("async reset");
    #2 rst_n = 1'b1;
    nextEdge();
    checkOutput("reboot no capture", 32'(bus.ifid_valid), 32'h0);
    checkOutput("reboot addr", 32'(bus.imem_addr), 32'h0);
    nextEdge();
    checkOutput("reboot capture valid", 32'(bus.ifid_valid), 32'h1);
    checkOutput("reboot capture pc", 32'(bus.ifid_pc), 32'h0);
    nextEdge(); nextEdge(); nextEdge();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
